// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} vend_state_e;

  localparam int unsigned PriceVecW = 256;

  // Extracts field idx of width w from a packed price vector.
  function automatic logic [31:0] price_at(input logic [PriceVecW-1:0] prices,
                                           input int unsigned idx,
                                           input int unsigned w);
    logic [PriceVecW-1:0] shifted;
    shifted = prices >> (idx * w);
    return shifted[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters: indexed decrement, bulk restock, zero flag for the indexed item.
module vend_stock_bank #(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned ITEM_W     = 2,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restock_i,
  input  logic              dec_i,
  input  logic [ITEM_W-1:0] idx_i,
  output logic              zero_o
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic               idx_ok;

  assign idx_ok = 32'(idx_i) < NUM_ITEMS;
  // Out-of-range indices read as empty so they can never be decremented.
  assign zero_o = idx_ok ? (stock_q[idx_i] == '0) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst || restock_i) begin
      for (int i = 0; i < int'(NUM_ITEMS); i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else if (dec_i && !zero_o) begin
      stock_q[idx_i] <= stock_q[idx_i] - STOCK_W'(1);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item coin vending controller with saturating credit, per-item stock and change handshake.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned COIN_W     = 5,
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned ITEM_W     = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int unsigned MAX_CREDIT = 50,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid_i,
  input  logic [COIN_W-1:0]   coin_val_i,
  input  logic                sel_valid_i,
  input  logic [ITEM_W-1:0]   sel_item_i,
  input  logic                cancel_i,
  input  logic                restock_i,
  input  logic                change_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                vend_o,
  output logic [ITEM_W-1:0]   vend_item_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] change_amt_o,
  output logic                coin_reject_o,
  output logic                sold_out_o,
  output logic                insufficient_o,
  output logic                busy_o
);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic                reject_q, reject_d;
  logic                sold_q, sold_d;
  logic                insuf_q, insuf_d;
  logic                stock_dec, stock_restock, stock_zero;
  logic                coin_present, sel_in_range;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] price;

  assign coin_present = coin_valid_i && (coin_val_i != '0);
  assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val_i);
  assign sel_in_range = 32'(sel_item_i) < NUM_ITEMS;
  assign price        = CREDIT_W'(price_at(PriceVecW'(PRICES), 32'(sel_item_i), CREDIT_W));

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .ITEM_W    (ITEM_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .restock_i(stock_restock),
    .dec_i    (stock_dec),
    .idx_i    (sel_item_i),
    .zero_o   (stock_zero)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    reject_d      = 1'b0;
    sold_d        = 1'b0;
    insuf_d       = 1'b0;
    stock_dec     = 1'b0;
    stock_restock = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        stock_restock = restock_i && (state_q == StIdle);
        // cancel > selection > coin; a coin losing arbitration is rejected
        if (cancel_i && (state_q == StCollect)) begin
          state_d  = StChange;
          reject_d = coin_present;
        end else if (sel_valid_i) begin
          reject_d = coin_present;
          if (!sel_in_range) begin
            insuf_d = 1'b1;
          end else if (stock_zero) begin
            sold_d = 1'b1;
          end else if (credit_q < price) begin
            insuf_d = 1'b1;
          end else begin
            state_d   = StVend;
            credit_d  = credit_q - price;
            item_d    = sel_item_i;
            stock_dec = 1'b1;
          end
        end else if (coin_present) begin
          if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StVend: begin
        reject_d = coin_present;
        state_d  = (credit_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        reject_d = coin_present;
        if (change_ready_i) begin
          credit_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      credit_q <= '0;
      item_q   <= '0;
      reject_q <= 1'b0;
      sold_q   <= 1'b0;
      insuf_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      sold_q   <= sold_d;
      insuf_q  <= insuf_d;
    end
  end

  assign credit_o       = credit_q;
  assign vend_o         = (state_q == StVend);
  assign vend_item_o    = item_q;
  assign change_valid_o = (state_q == StChange);
  assign change_amt_o   = credit_q;
  assign coin_reject_o  = reject_q;
  assign sold_out_o     = sold_q;
  assign insufficient_o = insuf_q;
  assign busy_o         = (state_q == StVend) || (state_q == StChange);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scenario bench for vend_ctrl_multi: expected per-cycle outputs queued, then compared to observations.
module tb_vend_ctrl_multi;

  typedef struct packed {
    logic [7:0] credit;
    logic       vend;
    logic [1:0] item;
    logic       cv;
    logic [7:0] amt;
    logic       rej;
    logic       sold;
    logic       insuf;
    logic       busy;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_val = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       change_ready = 1'b0;
  logic [7:0] credit, change_amt;
  logic       vend, change_valid, coin_reject, sold_out, insufficient, busy;
  logic [1:0] vend_item;

  out_t exp_q[$];
  out_t obs_q[$];
  int   checks = 0;
  int   failures = 0;

  vend_ctrl_multi dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid_i  (coin_valid),
    .coin_val_i    (coin_val),
    .sel_valid_i   (sel_valid),
    .sel_item_i    (sel_item),
    .cancel_i      (cancel),
    .restock_i     (restock),
    .change_ready_i(change_ready),
    .credit_o      (credit),
    .vend_o        (vend),
    .vend_item_o   (vend_item),
    .change_valid_o(change_valid),
    .change_amt_o  (change_amt),
    .coin_reject_o (coin_reject),
    .sold_out_o    (sold_out),
    .insufficient_o(insufficient),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // st: 0 idle/collect, 1 vend, 2 change
  function automatic out_t mk(input int cr, input int st, input int it,
                              input bit rj, input bit so, input bit ins);
    out_t o;
    o.credit = 8'(cr);
    o.vend   = (st == 1);
    o.item   = (st == 1) ? 2'(it) : 2'd0;
    o.cv     = (st == 2);
    o.amt    = (st == 2) ? 8'(cr) : 8'd0;
    o.rej    = rj;
    o.sold   = so;
    o.insuf  = ins;
    o.busy   = (st != 0);
    return o;
  endfunction

  task automatic cycle(input logic cv, input logic [4:0] cval, input logic sv,
                       input logic [1:0] si, input logic can, input logic rs, input logic rdy);
    out_t o;
    coin_valid = cv; coin_val = cval; sel_valid = sv; sel_item = si;
    cancel = can; restock = rs; change_ready = rdy;
    @(posedge clk);
    #1;
    o.credit = credit;
    o.vend   = vend;
    o.item   = vend ? vend_item : 2'd0;
    o.cv     = change_valid;
    o.amt    = change_valid ? change_amt : 8'd0;
    o.rej    = coin_reject;
    o.sold   = sold_out;
    o.insuf  = insufficient;
    o.busy   = busy;
    obs_q.push_back(o);
  endtask

  task automatic t_coin(input int v);   cycle(1, 5'(v), 0, 0, 0, 0, 0); endtask
  task automatic t_sel(input int i);    cycle(0, 0, 1, 2'(i), 0, 0, 0); endtask
  task automatic t_cancel();            cycle(0, 0, 0, 0, 1, 0, 0);     endtask
  task automatic t_idle();              cycle(0, 0, 0, 0, 0, 0, 0);     endtask
  task automatic t_ready();             cycle(0, 0, 0, 0, 0, 0, 1);     endtask
  task automatic t_restock();           cycle(0, 0, 0, 0, 0, 1, 0);     endtask

  task automatic test_reset();
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); cycle(1, 5, 1, 0, 1, 1, 1);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); t_idle();
    rst = 1'b0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_vend_change();
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(20, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(25, 0, 0, 0, 0, 0)); t_coin(5);
    exp_q.push_back(mk(10, 1, 1, 0, 0, 0)); t_sel(1);
    exp_q.push_back(mk(10, 2, 0, 0, 0, 0)); t_idle();
    exp_q.push_back(mk(10, 2, 0, 0, 0, 0)); t_idle();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL vend_change[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_insufficient_cancel();
    exp_q.push_back(mk(20, 0, 0, 0, 0, 0)); t_coin(20);
    exp_q.push_back(mk(20, 0, 0, 0, 0, 1)); t_sel(3);
    exp_q.push_back(mk(20, 2, 0, 0, 0, 0)); t_cancel();
    exp_q.push_back(mk(20, 2, 0, 0, 0, 0)); t_sel(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_cancel();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL insuf_cancel[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_credit_ceiling();
    exp_q.push_back(mk(25, 0, 0, 0, 0, 0)); t_coin(25);
    exp_q.push_back(mk(45, 0, 0, 0, 0, 0)); t_coin(20);
    exp_q.push_back(mk(45, 0, 0, 1, 0, 0)); t_coin(10);
    exp_q.push_back(mk(45, 0, 0, 0, 0, 0)); t_coin(0);
    exp_q.push_back(mk(50, 0, 0, 0, 0, 0)); t_coin(5);
    exp_q.push_back(mk(50, 0, 0, 1, 0, 0)); t_coin(1);
    exp_q.push_back(mk(50, 2, 0, 0, 0, 0)); t_cancel();
    exp_q.push_back(mk(50, 2, 0, 1, 0, 0)); t_coin(5);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ceiling[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_sold_out_restock();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0));  t_sel(0);
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0));  cycle(1, 5, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(10, 0, 0, 0, 1, 0)); t_sel(0);
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_restock();
    exp_q.push_back(mk(10, 0, 0, 0, 1, 0)); t_sel(0);
    exp_q.push_back(mk(10, 2, 0, 0, 0, 0)); t_cancel();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_restock();
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));  t_sel(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_idle();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sold_restock[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_priority();
    exp_q.push_back(mk(20, 0, 0, 0, 0, 0)); t_coin(20);
    exp_q.push_back(mk(20, 2, 0, 1, 0, 0)); cycle(1, 5, 1, 0, 1, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    exp_q.push_back(mk(15, 0, 0, 0, 0, 0)); t_coin(15);
    exp_q.push_back(mk(0, 1, 1, 1, 0, 0));  cycle(1, 5, 1, 1, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_idle();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL priority[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  task automatic test_reset_in_change();
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));  t_sel(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_idle();
    exp_q.push_back(mk(15, 0, 0, 0, 0, 0)); t_coin(15);
    exp_q.push_back(mk(15, 2, 0, 0, 0, 0)); t_cancel();
    exp_q.push_back(mk(15, 2, 0, 0, 0, 0)); t_idle();
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_idle();
    rst = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    // All stock back at STOCK_INIT: three vends of item 0, then sold out.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0));  t_sel(0);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_idle();
    end
    exp_q.push_back(mk(10, 0, 0, 0, 0, 0)); t_coin(10);
    exp_q.push_back(mk(10, 0, 0, 0, 1, 0)); t_sel(0);
    exp_q.push_back(mk(10, 2, 0, 0, 0, 0)); t_cancel();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));  t_ready();
    for (int n = 0; exp_q.size() > 0; n++) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_in_change[%0d] got=%p want=%p", n, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_insufficient_cancel();
    test_credit_ceiling();
    test_sold_out_restock();
    test_priority();
    test_reset_in_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
